// File: rtl/mux_rr_stream.sv
// N-channel round-robin stream mux with one registered output stage.
// Define MUX_RR_CNT_EN to add the 16-bit xfer_cnt output-transfer counter.
module mux_rr_stream #(
  parameter int WIDTH = 4,
  parameter int CHANNELS = 4,
  localparam int CW = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  output logic [CHANNELS-1:0]       in_ready,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic [CW-1:0]             out_chan,
  input  logic                      out_ready
`ifdef MUX_RR_CNT_EN
  ,
  output logic [15:0]               xfer_cnt
`endif
);

  logic [CW-1:0]    ptr;
  logic [CW-1:0]    gnt;
  logic [CW:0]      cand;
  logic             hit;
  logic             free;
  logic             take;
  logic [WIDTH-1:0] chan_data [CHANNELS];

  for (genvar c = 0; c < CHANNELS; c++) begin : g_split
    assign chan_data[c] = in_data[c*WIDTH +: WIDTH];
  end

  // Scan ptr+1 .. ptr+CHANNELS; the explicit subtract keeps
  // non-power-of-two channel counts wrapping at CHANNELS.
  always_comb begin
    gnt  = '0;
    hit  = 1'b0;
    cand = '0;
    for (int k = 1; k <= CHANNELS; k++) begin
      cand = {1'b0, ptr} + (CW+1)'(k);
      if (cand >= (CW+1)'(CHANNELS))
        cand = cand - (CW+1)'(CHANNELS);
      if (!hit && in_valid[cand[CW-1:0]]) begin
        hit = 1'b1;
        gnt = cand[CW-1:0];
      end
    end
  end

  assign free = !out_valid || out_ready;
  assign take = hit && free && !rst;

  always_comb begin
    in_ready = '0;
    if (take)
      in_ready[gnt] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      ptr       <= CW'(CHANNELS - 1);
    end else if (take) begin
      out_valid <= 1'b1;
      out_data  <= chan_data[gnt];
      out_chan  <= gnt;
      ptr       <= gnt;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef MUX_RR_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      xfer_cnt <= '0;
    else if (out_valid && out_ready)
      xfer_cnt <= xfer_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_mux_rr_stream.sv
// Bench for mux_rr_stream: vector table, random run against a
// reference model, mid-stream reset and a 3-channel instance.
module tb_mux_rr_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  iv;
  logic [15:0] id;
  logic [3:0]  ir;
  logic        ov;
  logic [3:0]  od;
  logic [1:0]  oc;
  logic        ordy;

  logic [2:0]  iv3 = 3'b111;
  logic [11:0] id3 = 12'h321;
  logic [2:0]  ir3;
  logic        ov3;
  logic [3:0]  od3;
  logic [1:0]  oc3;
  logic        ordy3 = 1'b1;

`ifdef MUX_RR_CNT_EN
  logic [15:0] xfer_cnt;
  logic [15:0] xfer_cnt3;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mux_rr_stream #(.WIDTH(4), .CHANNELS(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(iv), .in_data(id), .in_ready(ir),
    .out_valid(ov), .out_data(od), .out_chan(oc),
    .out_ready(ordy)
`ifdef MUX_RR_CNT_EN
    , .xfer_cnt(xfer_cnt)
`endif
  );

  mux_rr_stream #(.WIDTH(4), .CHANNELS(3)) dut3 (
    .clk(clk), .rst(rst),
    .in_valid(iv3), .in_data(id3), .in_ready(ir3),
    .out_valid(ov3), .out_data(od3), .out_chan(oc3),
    .out_ready(ordy3)
`ifdef MUX_RR_CNT_EN
    , .xfer_cnt(xfer_cnt3)
`endif
  );

  task automatic chk(input string name,
                     input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t",
               name, act, exp, $time);
    end
  endtask

  function automatic int grant(input int p, input logic [3:0] v);
    for (int k = 1; k <= 4; k++) begin
      int i;
      i = (p + k) % 4;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  typedef struct {
    logic [3:0]  v;
    logic [15:0] d;
    logic        r;
    logic [3:0]  erdy;
    logic        eov;
    logic [3:0]  eod;
    logic [1:0]  eoc;
  } vec_t;

  vec_t tbl [15];

  int          mptr;
  logic        mov;
  logic [3:0]  mod;
  logic [1:0]  moc;
  logic [15:0] mcnt;
  logic [3:0]  erdy;
  logic [3:0]  pend;
  logic [3:0]  pdat [4];
  int          g;

  initial begin
    tbl[0]  = '{4'b1111, 16'h4321, 1'b1, 4'b0001, 1'b1, 4'h1, 2'd0};
    tbl[1]  = '{4'b1111, 16'h4321, 1'b1, 4'b0010, 1'b1, 4'h2, 2'd1};
    tbl[2]  = '{4'b1111, 16'h4321, 1'b1, 4'b0100, 1'b1, 4'h3, 2'd2};
    tbl[3]  = '{4'b1111, 16'h4321, 1'b1, 4'b1000, 1'b1, 4'h4, 2'd3};
    tbl[4]  = '{4'b1111, 16'h4321, 1'b1, 4'b0001, 1'b1, 4'h1, 2'd0};
    tbl[5]  = '{4'b0100, 16'h0A00, 1'b1, 4'b0100, 1'b1, 4'hA, 2'd2};
    tbl[6]  = '{4'b0001, 16'h0005, 1'b1, 4'b0001, 1'b1, 4'h5, 2'd0};
    tbl[7]  = '{4'b0001, 16'h000F, 1'b1, 4'b0001, 1'b1, 4'hF, 2'd0};
    tbl[8]  = '{4'b0010, 16'h00B0, 1'b0, 4'b0000, 1'b1, 4'hF, 2'd0};
    tbl[9]  = '{4'b0010, 16'h00B0, 1'b0, 4'b0000, 1'b1, 4'hF, 2'd0};
    tbl[10] = '{4'b0010, 16'h00B0, 1'b0, 4'b0000, 1'b1, 4'hF, 2'd0};
    tbl[11] = '{4'b0010, 16'h00B0, 1'b1, 4'b0010, 1'b1, 4'hB, 2'd1};
    tbl[12] = '{4'b0000, 16'h0000, 1'b1, 4'b0000, 1'b0, 4'hB, 2'd1};
    tbl[13] = '{4'b0000, 16'h0000, 1'b0, 4'b0000, 1'b0, 4'hB, 2'd1};
    tbl[14] = '{4'b1000, 16'h7000, 1'b0, 4'b1000, 1'b1, 4'h7, 2'd3};

    rst = 1'b1; iv = '0; id = '0; ordy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 16'(ov), 16'h0);
    chk("rst_out_data", 16'(od), 16'h0);
    chk("rst_out_chan", 16'(oc), 16'h0);
    chk("rst_in_ready", 16'(ir), 16'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int n = 0; n < 15; n++) begin
      iv = tbl[n].v; id = tbl[n].d; ordy = tbl[n].r;
      #1;
      chk($sformatf("tbl%0d_in_ready", n), 16'(ir), 16'(tbl[n].erdy));
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_out_valid", n), 16'(ov), 16'(tbl[n].eov));
      chk($sformatf("tbl%0d_out_data", n), 16'(od), 16'(tbl[n].eod));
      chk($sformatf("tbl%0d_out_chan", n), 16'(oc), 16'(tbl[n].eoc));
    end

    // Random run with well-behaved producers against the model.
    rst = 1'b1; iv = '0; ordy = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    mptr = 3; mov = 1'b0; mod = '0; moc = '0; mcnt = '0; pend = '0;
    for (int i = 0; i < 4; i++) pdat[i] = '0;
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 4; i++) begin
        if (!pend[i] && ($urandom_range(0, 1) == 1)) begin
          pend[i] = 1'b1;
          pdat[i] = 4'($urandom_range(0, 15));
        end
      end
      iv = pend;
      for (int i = 0; i < 4; i++)
        id[i*4 +: 4] = pend[i] ? pdat[i] : 4'($urandom_range(0, 15));
      ordy = ($urandom_range(0, 3) != 0);
      #1;
      g = grant(mptr, iv);
      erdy = '0;
      if (g >= 0 && (!mov || ordy)) erdy[g] = 1'b1;
      chk("rnd_in_ready", 16'(ir), 16'(erdy));
      @(posedge clk);
      #1;
      if (mov && ordy) mcnt = mcnt + 16'd1;
      if (erdy != 4'b0) begin
        mov = 1'b1; mod = pdat[g]; moc = 2'(g); mptr = g;
        pend[g] = 1'b0;
      end else if (ordy) begin
        mov = 1'b0;
      end
      chk("rnd_out_valid", 16'(ov), 16'(mov));
      chk("rnd_out_data", 16'(od), 16'(mod));
      chk("rnd_out_chan", 16'(oc), 16'(moc));
`ifdef MUX_RR_CNT_EN
      chk("rnd_xfer_cnt", xfer_cnt, mcnt);
`endif
    end

    // Asynchronous reset while a beat is held.
    iv = 4'b0100; id = 16'h0C00; ordy = 1'b1;
    @(posedge clk);
    #1;
    chk("pre_rst_out_valid", 16'(ov), 16'h1);
    chk("pre_rst_out_data", 16'(od), 16'hC);
    ordy = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_out_valid", 16'(ov), 16'h0);
    chk("async_rst_out_data", 16'(od), 16'h0);
    chk("async_rst_out_chan", 16'(oc), 16'h0);
    chk("async_rst_in_ready", 16'(ir), 16'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; iv = 4'b1111; id = 16'h4321; ordy = 1'b1;
    for (int k = 0; k < 7; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("post_rst_chan%0d", k), 16'(oc), 16'(k % 4));
      chk($sformatf("post_rst_data%0d", k), 16'(od), 16'(k % 4 + 1));
      chk($sformatf("ch3_valid%0d", k), 16'(ov3), 16'h1);
      chk($sformatf("ch3_chan%0d", k), 16'(oc3), 16'(k % 3));
      chk($sformatf("ch3_data%0d", k), 16'(od3), 16'(k % 3 + 1));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
